// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: reset vector, instruction step and the
// redirect FSM state encoding.
package cpu_defs;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hbfc0_0000;
  localparam int          INSTR_STEP      = 4;

  typedef logic state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_PEND = 1'b1;

endpackage : cpu_defs

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for a branch/jump target that arrived while fetch was
// stalled. A simultaneous load and clear keeps the new target but drops valid.
module pc_redirect_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_target,
  output logic [WIDTH-1:0] o_target,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_target;
  logic             r_valid;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (i_load)
        r_target <= i_target;
      else if (i_clear)
        r_target <= '0;

      if (i_clear)
        r_valid <= 1'b0;
      else if (i_load)
        r_valid <= 1'b1;
    end
  end

  assign o_target = r_target;
  assign o_valid  = r_valid;

endmodule : pc_redirect_buf

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter: reset > flush > redirect > sequential step,
// with stalled redirects parked in pc_redirect_buf until en returns.
module pc_fetch_ctrl
  import cpu_defs::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int               STEP         = INSTR_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] newpc,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             redir_pending,
  output logic             adel,
  output logic             fetch_valid
);

  logic [WIDTH-1:0] r_pc;
  state_t           r_state;

  logic [WIDTH-1:0] w_pc_next;
  state_t           w_state_next;
  logic [WIDTH-1:0] w_pc_plus_step;
  logic [WIDTH-1:0] w_pend_target;
  logic             w_pend_valid;
  logic             w_buf_load;
  logic             w_buf_clear;

  // Wraps modulo 2^WIDTH; there is deliberately no carry out.
  assign w_pc_plus_step = r_pc + WIDTH'(STEP);

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_pc_next    = r_pc;
    w_state_next = r_state;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;

    if (flush) begin
      // Flush discards both an incoming and a buffered redirect.
      w_pc_next    = newpc;
      w_state_next = ST_IDLE;
      w_buf_clear  = 1'b1;
    end else if (r_state == ST_IDLE) begin
      if (redir_valid && en) begin
        w_pc_next = redir_target;
      end else if (redir_valid) begin
        w_buf_load   = 1'b1;
        w_state_next = ST_PEND;
      end else if (en) begin
        w_pc_next = w_pc_plus_step;
      end
    end else begin
      if (redir_valid) begin
        // The most recent redirect always replaces the buffered one.
        w_buf_load = 1'b1;
        if (en) begin
          w_pc_next    = redir_target;
          w_state_next = ST_IDLE;
          w_buf_clear  = 1'b1;
        end
      end else if (en) begin
        w_pc_next    = w_pend_target;
        w_state_next = ST_IDLE;
        w_buf_clear  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_VECTOR;
      r_state <= ST_IDLE;
    end else begin
      r_pc    <= w_pc_next;
      r_state <= w_state_next;
    end
  end

  pc_redirect_buf #(
    .WIDTH (WIDTH)
  ) u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_buf_load),
    .i_clear  (w_buf_clear),
    .i_target (redir_target),
    .o_target (w_pend_target),
    .o_valid  (w_pend_valid)
  );

  assign pc            = r_pc;
  assign pc_plus_step  = w_pc_plus_step;
  assign redir_pending = w_pend_valid;
  assign adel          = |r_pc[1:0];
  assign fetch_valid   = !adel && !rst;

endmodule : pc_fetch_ctrl

// File: tb/tb_pc_fetch_ctrl.sv
// Directed-vector bench for pc_fetch_ctrl: reset, stepping, redirects (live
// and stalled), flush priority, misalignment, wrap and async reset mid-PEND.
module tb_pc_fetch_ctrl;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] newpc;
  logic             redir_valid;
  logic [WIDTH-1:0] redir_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_step;
  logic             redir_pending;
  logic             adel;
  logic             fetch_valid;

  int n_vectors;
  int n_miscompares;

  pc_fetch_ctrl #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (32'hbfc0_0000),
    .STEP         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .flush         (flush),
    .newpc         (newpc),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .pc            (pc),
    .pc_plus_step  (pc_plus_step),
    .redir_pending (redir_pending),
    .adel          (adel),
    .fetch_valid   (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("FAIL %s: got %08h, want %08h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v_en, input logic v_flush,
                       input logic [31:0] v_newpc, input logic v_redir,
                       input logic [31:0] v_target);
    en           = v_en;
    flush        = v_flush;
    newpc        = v_newpc;
    redir_valid  = v_redir;
    redir_target = v_target;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("rst_pc",      pc,            32'hbfc0_0000);
    check("rst_fv",      fetch_valid,   32'h0);
    check("rst_pend",    redir_pending, 32'h0);
    check("rst_adel",    adel,          32'h0);
    step();
    step();
    check("rst_hold_pc", pc,            32'hbfc0_0000);
    check("rst_hold_fv", fetch_valid,   32'h0);

    // Reset then run.
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("run0_pc", pc,          32'hbfc0_0000);
    check("run0_fv", fetch_valid, 32'h1);
    check("run0_ps", pc_plus_step, 32'hbfc0_0004);
    step(); check("run1_pc", pc, 32'hbfc0_0004);
    step(); check("run2_pc", pc, 32'hbfc0_0008);
    step(); check("run3_pc", pc, 32'hbfc0_000c);
    step(); check("run4_pc", pc, 32'hbfc0_0010);

    // Redirect unstalled.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_1000);
    step(); check("redir_pc",   pc,            32'h8000_1000);
    check("redir_pend", redir_pending, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check("redir_inc",  pc,            32'h8000_1004);

    // Redirect during stall: 3 stalled cycles, then release.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_2000);
    step(); check("stall0_pc",   pc,            32'h8000_1004);
    check("stall0_pend", redir_pending, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check("stall1_pc",   pc,            32'h8000_1004);
    check("stall1_pend", redir_pending, 32'h1);
    step(); check("stall2_pc",   pc,            32'h8000_1004);
    check("stall2_pend", redir_pending, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check("release_pc",   pc,            32'h8000_2000);
    check("release_pend", redir_pending, 32'h0);
    step(); check("release_inc",  pc,            32'h8000_2004);

    // Last buffered redirect wins.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_5000);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_6000);
    step(); check("lastwin_hold", pc,            32'h8000_2004);
    check("lastwin_pend", redir_pending, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check("lastwin_pc",   pc,            32'h8000_6000);

    // Redirect arriving in PEND with en high goes straight to pc.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_7000);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_8000);
    step(); check("pend_live_pc",   pc,            32'h8000_8000);
    check("pend_live_pend", redir_pending, 32'h0);

    // Flush in PEND with en low and a competing redirect.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_4000);
    step(); check("fpend_pre", redir_pending, 32'h1);
    drive(1'b0, 1'b1, 32'hbfc0_0380, 1'b1, 32'h8000_3000);
    step(); check("fpend_pc",   pc,            32'hbfc0_0380);
    check("fpend_pend", redir_pending, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check("fpend_drop", pc,            32'hbfc0_0384);

    // Flush in IDLE with en high and a competing redirect.
    drive(1'b1, 1'b1, 32'hbfc0_0380, 1'b1, 32'h8000_3000);
    step(); check("fidle_pc",   pc,            32'hbfc0_0380);
    check("fidle_pend", redir_pending, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check("fidle_inc",  pc,            32'hbfc0_0384);

    // Misaligned target: flagged, but the PC keeps advancing.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0002);
    step(); check("mis_pc",   pc,           32'h8000_0002);
    check("mis_adel", adel,         32'h1);
    check("mis_fv",   fetch_valid,  32'h0);
    check("mis_ps",   pc_plus_step, 32'h8000_0006);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check("mis_adv",  pc,           32'h8000_0006);
    check("mis_adel2", adel,        32'h1);

    // Wrap at the top of the address space.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hffff_fffc);
    step(); check("wrap_pre", pc,           32'hffff_fffc);
    check("wrap_ps",  pc_plus_step, 32'h0000_0000);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check("wrap_pc",  pc,           32'h0000_0000);
    check("wrap_fv",  fetch_valid,  32'h1);

    // Async reset between edges while a redirect is buffered.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_9000);
    step(); check("arst_pre", redir_pending, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc",   pc,            32'hbfc0_0000);
    check("arst_pend", redir_pending, 32'h0);
    check("arst_fv",   fetch_valid,   32'h0);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("arst_rel_fv", fetch_valid, 32'h1);
    step(); check("arst_lost", pc, 32'hbfc0_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule : tb_pc_fetch_ctrl

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Parametrised program-counter generator for the fetch stage of the MIPS pipeline. It holds the fetch PC and applies, in fixed priority, reset, exception/ERET flush, branch/jump redirect and sequential increment. A branch redirect that arrives while fetch is stalled is held in a one-entry buffer until the stall releases. The block also flags misaligned fetch addresses for the exception unit.

## Interface
Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VECTOR, 32'hbfc00000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  fetch advance; 0 = stall and hold the PC.
- flush  in  1  exception/ERET redirect; applied regardless of en.
- newpc  in  WIDTH  flush target.
- redir_valid  in  1  branch/jump taken, one-cycle pulse from decode.
- redir_target  in  WIDTH  branch/jump target.
- pc  out  WIDTH  current fetch PC, registered.
- pc_plus_step  out  WIDTH  pc + STEP, combinational.
- redir_pending  out  1  high while a buffered redirect waits (state PEND).
- adel  out  1  pc[1:0] != 0, combinational.
- fetch_valid  out  1  !adel && !rst; the instruction at pc may be issued.

## Operation
- Next-PC priority: rst > flush > applied redirect > en ? pc+STEP : hold.
- FSM states: IDLE, PEND. A 1-bit state register and a WIDTH-bit pend_target register.
- IDLE:
  - flush: pc <= newpc; any redir_valid in the same cycle is discarded.
  - redir_valid && en: pc <= redir_target.
  - redir_valid && !en: pend_target <= redir_target, go to PEND; pc holds.
  - otherwise: increment if en, hold if !en.
- PEND:
  - flush: pc <= newpc, go to IDLE, pending target dropped.
  - redir_valid (any en): pend_target <= redir_target; the last redirect wins. If en = 1, pc <= redir_target directly and go to IDLE.
  - en && !redir_valid: pc <= pend_target, go to IDLE.
  - !en: hold pc and pend_target.
- Arithmetic: pc + STEP is modulo 2^WIDTH. 32'hfffffffc + 4 wraps to 0; no carry flag.
- adel does not block updates. The PC keeps advancing; the exception unit is expected to flush.

## Timing
- Reset values (asynchronous, immediate):
  - pc = RESET_VECTOR
  - state = IDLE, pend_target = 0, redir_pending = 0
  - adel = 0 (for an aligned vector)
  - fetch_valid = 0 while rst is asserted
- First fetch_valid = 1 in the cycle after rst deasserts; pc = RESET_VECTOR in that cycle.
- Redirect latency: 1 edge from redir_valid to pc = target when en = 1. When stalled, the target appears on the edge on which en is first sampled high.
- Flush latency: 1 edge, independent of en and state.
- Reset asserted mid-PEND: the buffered target is lost; the block returns to reset values asynchronously.
- redir_valid is sampled only on clock edges. A pulse that spans several stalled cycles is captured each cycle (same target, harmless).

## Structure
- Shared package (cpu_defs): PC_RESET_VECTOR, INSTR_STEP, and the FSM state typedef with encodings IDLE=0, PEND=1.
- Natural sub-module: pc_redirect_buf, holding the one-entry pending-redirect register with load/clear/valid. The top level keeps the FSM, the PC register and the next-PC mux.
- No memories and no multi-clock logic.

## Test plan
- Reset then run: assert rst, release, en = 1 for 3 cycles.
  - Required: pc = bfc00000, bfc00004, bfc00008, bfc0000c; fetch_valid = 0 during reset.
- Redirect unstalled: at pc = bfc00010, redir_valid with target 80001000 and en = 1.
  - Required: next pc = 80001000, then 80001004.
- Redirect during stall: en = 0, redir_valid with target 80002000.
  - Required: redir_pending = 1 and pc holds for 3 stalled cycles.
  - Then en = 1: pc = 80002000 on the next edge, redir_pending = 0.
- Flush beats everything:
  - In PEND with en = 0, flush with newpc = bfc00380 and redir_valid with target 80003000 together. Required: pc = bfc00380, state IDLE, pending target dropped.
  - Repeat in IDLE with en = 1. Required: same pc result.
- Misaligned and wrap:
  - redir_target = 80000002. Required: adel = 1, fetch_valid = 0 while pc = 80000002.
  - pc = fffffffc with en = 1. Required: next pc = 00000000.
- Async reset mid-PEND: assert rst between edges. Required: pc = bfc00000 and redir_pending = 0 before the next edge.
